// File: rtl/gpu_pkg.sv
// Shared GPU constants: asset store geometry and sprite base addresses.
// The base addresses are used by the game logic that builds GPU ops.
package gpu_pkg;

    localparam int ASSET_MEM_SIZE       = 654;
    localparam int ASSET_MEM_ADDR_WIDTH = 10;

    // Sprite base pixel indices; pixel = base + row*width + col (row-major).
    localparam logic [ASSET_MEM_ADDR_WIDTH-1:0] SPRITE_PLAYER_BASE = 10'd0;
    localparam logic [ASSET_MEM_ADDR_WIDTH-1:0] SPRITE_ENEMY_BASE  = 10'd256;
    localparam logic [ASSET_MEM_ADDR_WIDTH-1:0] SPRITE_BULLET_BASE = 10'd512;
    localparam logic [ASSET_MEM_ADDR_WIDTH-1:0] SPRITE_FONT_BASE   = 10'd528;

endpackage

// File: rtl/asset_memory.sv
// Bit-per-pixel sprite store: combinational read, synchronous patch write,
// asynchronous reset back to the preloaded image (bit i of INIT_IMAGE = pixel i).
module asset_memory
    import gpu_pkg::*;
#(
    parameter int              SIZE       = ASSET_MEM_SIZE,
    parameter int              ADDR_WIDTH = ASSET_MEM_ADDR_WIDTH,
    parameter logic [SIZE-1:0] INIT_IMAGE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  out,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_data
);

    localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

    // Flop array rather than block RAM: reset must restore every bit at once.
    logic [SIZE-1:0] mem_q;
    logic [SIZE-1:0] mem_d;
    logic            wr_hit;
    logic            rd_hit;

    assign wr_hit = wr_en && ({1'b0, wr_addr} < SIZE_W);
    assign rd_hit = ({1'b0, addr} < SIZE_W);

    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= INIT_IMAGE;
        end else begin
            mem_q <= mem_d;
        end
    end

    // No write bypass: a same-cycle write shows up only after the edge.
    assign out = rd_hit ? mem_q[addr] : 1'b0;

endmodule

// File: tb/tb_asset_memory.sv
// Directed bench for asset_memory with an alternating 0,1 preload image.
module tb_asset_memory;

    localparam int SIZE = 654;
    localparam int AW   = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_drv;
    logic [AW-1:0] addr;
    logic          out;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;

    logic          pipe_on;
    logic [AW-1:0] pipe_addr;
    logic          pipe_out;

    logic [SIZE-1:0] model;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign addr = pipe_on ? pipe_addr : addr_drv;

    asset_memory #(
        .SIZE      (SIZE),
        .ADDR_WIDTH(AW),
        .INIT_IMAGE({327{2'b10}})
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .out    (out),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    // Models the GPU consumer: registered address, registered read data.
    always @(posedge clk) begin
        if (pipe_on) begin
            pipe_addr <= pipe_addr + 1'b1;
            pipe_out  <= out;
        end
    end

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        addr_drv  = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = 1'b0;
        pipe_on   = 1'b0;
        pipe_addr = '0;
        for (int i = 0; i < SIZE; i++) model[i] = i[0];

        #2;
        addr_drv = 10'd1;
        #1 chk("reset_out", 1, out, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Preload sweep over the whole address space
        for (int i = 0; i < 1024; i++) begin
            addr_drv = i[AW-1:0];
            #1 chk("preload", i, out, (i < SIZE) ? i[0] : 1'b0);
        end

        // Patch addr 1 <- 0 and addr 0 <- 1
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 10'd1; wr_data = 1'b0;
        @(negedge clk);
        wr_addr = 10'd0; wr_data = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        model[1] = 1'b0; model[0] = 1'b1;
        addr_drv = 10'd0; #1 chk("write_a0", 0, out, 1'b1);
        addr_drv = 10'd1; #1 chk("write_a1", 1, out, 1'b0);
        addr_drv = 10'd2; #1 chk("write_a2", 2, out, 1'b0);

        // Read during write to the same address
        @(negedge clk);
        addr_drv = 10'd5; wr_en = 1'b1; wr_addr = 10'd5; wr_data = 1'b0;
        #1 chk("rdw_before", 5, out, 1'b1);
        @(posedge clk);
        #1 chk("rdw_after", 5, out, 1'b0);
        model[5] = 1'b0;

        // Out-of-range write is dropped
        @(negedge clk);
        wr_addr = 10'd700; wr_data = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            addr_drv = i[AW-1:0];
            #1 chk("oor_image", i, out, model[i]);
        end
        addr_drv = 10'd700;
        #1 chk("oor_read", 700, out, 1'b0);

        // Async reset between edges, with a write held during reset
        @(negedge clk);
        addr_drv = 10'd1;
        #2 rst = 1'b1;
        #1 chk("async_rst_a1", 1, out, 1'b1);
        wr_en = 1'b1; wr_addr = 10'd3; wr_data = 1'b0;
        @(posedge clk);
        addr_drv = 10'd3;
        #1 chk("wr_in_rst", 3, out, 1'b1);
        addr_drv = 10'd0;
        #1 chk("rst_a0", 0, out, 1'b0);
        addr_drv = 10'd5;
        #1 chk("rst_a5", 5, out, 1'b1);
        for (int i = 0; i < SIZE; i++) model[i] = i[0];

        // First write after release lands on the first edge
        @(negedge clk);
        rst = 1'b0;
        addr_drv = 10'd3;
        #1 chk("post_rst_before", 3, out, 1'b1);
        @(posedge clk);
        #1 chk("post_rst_write", 3, out, 1'b0);
        model[3] = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;

        // GPU pipeline: address registered at edge k, data registered at k+1
        pipe_addr = '0;
        pipe_on   = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            #1 chk("pipe", k, pipe_out, model[k]);
        end
        pipe_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
